instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Builds 32-bit machine words from operation descriptors. Uses the opcode and funct map that the control unit decodes.
//  Writes each word in order into instruction memory, starting at BASE_ADDR.
//  Sits between the testbench or boot source and the instruction memory write port. It is the inverse of the decoder.
// PARAMETERS
//  ADDR_W     8  word-address width of the instruction memory
//  DEPTH      256  maximum number of words stored; DEPTH <= 2**ADDR_W - BASE_ADDR
//  BASE_ADDR  0  word address of the first write
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  clear       in   1   synchronous; resets pointer and err, returns FSM to IDLE
//  op_valid    in   1   descriptor valid
//  op_ready    out  1   loader can accept a descriptor
//  op_kind     in   5   0 add,1 sub,2 addu,3 subu,4 and,5 or,6 sll,7 srl,8 slt,9 jr,10 addi,11 addiu,12 slti,
//                       13 sltiu,14 andi,15 ori,16 beq,17 bne,18 bgt,19 bgte,20 ble,21 bleq,22 j,23 jal,24 lw,25 sw; 26-31 illegal
//  rs,rt,rd    in   5   register fields
//  imm         in   16  immediate or branch offset, placed raw (no extension)
//  target      in   26  jump target field
//  imem_we     out  1   one-cycle write strobe
//  imem_addr   out  ADDR_W  write word address
//  imem_wdata  out  32  encoded instruction
//  count       out  ADDR_W+1  words written since reset or clear
//  full        out  1   count == DEPTH
//  err         out  1   sticky; set on an illegal op_kind
// BEHAVIOUR
//  Reset values: op_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0, FSM=IDLE.
//  FSM states:
//   IDLE  -> op_ready=1. On op_valid&op_ready the descriptor is latched.
//            Legal kind: go to WRITE. Illegal kind: set err, stay in IDLE, write nothing.
//   WRITE -> imem_we=1 for exactly one cycle.
//            imem_addr=BASE_ADDR+count, imem_wdata=encoded word. count increments at the end of the cycle.
//            Next state is FULL if the new count==DEPTH, otherwise IDLE.
//   FULL  -> op_ready=0, full=1. Only clear or rst_n leaves this state (to IDLE).
//  Latency: accept at cycle N, strobe at N+1, op_ready high again at N+2. Throughput is 1 word per 2 cycles.
//  op_ready=0 in WRITE and FULL. A descriptor held valid there is not consumed; the source must hold it stable.
//  Encoding (op = bits 31:26):
//   R-type (kinds 0-8): {6'b0,rs,rt,rd,5'b0,funct}
//     funct: add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, sll 000000, srl 000010, slt 101010.
//   jr: {6'b0,rs,15'b0,6'b001000}.
//   I-type: {op,rs,rt,imm}
//     op: addi 001000, addiu 001001, slti 001010, sltiu 001011, andi 001100, ori 001101.
//   Branches: same I-type format.
//     op: beq 011000, bne 011001, bgt 011010, bgte 011011, ble 011100, bleq 011110.
//   lw 100011, sw 101011: I-type format.
//   j 000010, jal 000011: {op,target}.
//  Unused register fields of the descriptor are ignored. imem_wdata holds its last value while imem_we=0.
//  clear in the same cycle as op_valid: clear wins, nothing is accepted, err=0.
//  clear during WRITE: the strobe is suppressed and count=0 on the next cycle.
//  rst_n low mid-WRITE: outputs go to reset values immediately and no strobe completes.
//  count never wraps. At count==DEPTH the FSM parks in FULL.
//  imem_addr is held at BASE_ADDR+count outside WRITE.
// TESTING
//  1. add: kind=0 rs=1 rt=2 rd=3 -> next cycle imem_we=1, addr=0, wdata=0x00221820; count=1.
//  2. addi then jr: (a) kind=10 rt=4 imm=0xFFFF -> wdata=0x2004FFFF (no sign extension), addr=1.
//     (b) kind=9 rs=31 -> wdata=0x03E00008, addr=2.
//  3. jal then sw: (a) kind=23 target=0x10 -> wdata=0x0C000010.
//     (b) kind=25 rs=29 rt=31 imm=8 -> wdata=0xAFBF0008.
//  4. Illegal kind=31 -> no imem_we, err=1 and sticky, count unchanged, op_ready=1 next cycle.
//     Then clear -> err=0.
//  5. DEPTH=4: four legal ops -> full=1 and op_ready=0. A fifth op_valid is held with no strobe.
//     Then clear -> count=0, imem_addr=BASE_ADDR, op_ready=1.
//  6. Assert rst_n=0 during the WRITE cycle -> imem_we drops immediately and count=0.
//     After release, the first write is to addr=BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_loader_if
//  Description : Descriptor handshake and instruction-memory write bus between
//                a boot/test source and the instruction encoder loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  // Descriptor channel
  logic              op_valid;
  logic              op_ready;
  logic [4:0]        op_kind;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  // Instruction memory write port and status
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  // Source side: supplies descriptors, observes the write port and status
  modport master (
    output op_valid, op_kind, rs, rt, rd, imm, target,
    input  op_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );

  // Loader side
  modport slave (
    input  op_valid, op_kind, rs, rt, rd, imm, target,
    output op_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_loader
//  Description : Encodes operation descriptors into 32-bit MIPS-style machine
//                words and writes them sequentially into instruction memory
//                starting at BASE_ADDR. Illegal kinds set a sticky error.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clear,
  instr_encoder_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   c_depth     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_one       = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_op_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_err;

  logic [31:0]       w_word;
  logic              w_legal;
  logic [ADDR_W:0]   w_count_nxt;
  logic              w_accept;

  function automatic logic [31:0] f_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] f_itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Map the descriptor to its machine word; unlisted kinds are illegal
  always_comb begin
    w_legal = 1'b1;
    w_word  = 32'h0;
    case (bus.op_kind)
      5'd0:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 6'b100000); // add
      5'd1:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 6'b100010); // sub
      5'd2:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 6'b100001); // addu
      5'd3:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 6'b100011); // subu
      5'd4:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 6'b100100); // and
      5'd5:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 6'b100101); // or
      5'd6:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 6'b000000); // sll
      5'd7:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 6'b000010); // srl
      5'd8:  w_word = f_rtype(bus.rs, bus.rt, bus.rd, 6'b101010); // slt
      5'd9:  w_word = {6'b000000, bus.rs, 15'b0, 6'b001000};      // jr
      5'd10: w_word = f_itype(6'b001000, bus.rs, bus.rt, bus.imm); // addi
      5'd11: w_word = f_itype(6'b001001, bus.rs, bus.rt, bus.imm); // addiu
      5'd12: w_word = f_itype(6'b001010, bus.rs, bus.rt, bus.imm); // slti
      5'd13: w_word = f_itype(6'b001011, bus.rs, bus.rt, bus.imm); // sltiu
      5'd14: w_word = f_itype(6'b001100, bus.rs, bus.rt, bus.imm); // andi
      5'd15: w_word = f_itype(6'b001101, bus.rs, bus.rt, bus.imm); // ori
      5'd16: w_word = f_itype(6'b011000, bus.rs, bus.rt, bus.imm); // beq
      5'd17: w_word = f_itype(6'b011001, bus.rs, bus.rt, bus.imm); // bne
      5'd18: w_word = f_itype(6'b011010, bus.rs, bus.rt, bus.imm); // bgt
      5'd19: w_word = f_itype(6'b011011, bus.rs, bus.rt, bus.imm); // bgte
      5'd20: w_word = f_itype(6'b011100, bus.rs, bus.rt, bus.imm); // ble
      5'd21: w_word = f_itype(6'b011110, bus.rs, bus.rt, bus.imm); // bleq
      5'd22: w_word = {6'b000010, bus.target};                     // j
      5'd23: w_word = {6'b000011, bus.target};                     // jal
      5'd24: w_word = f_itype(6'b100011, bus.rs, bus.rt, bus.imm); // lw
      5'd25: w_word = f_itype(6'b101011, bus.rs, bus.rt, bus.imm); // sw
      default: w_legal = 1'b0;
    endcase
  end

  assign w_count_nxt = r_count + c_one;
  assign w_accept    = bus.op_valid && r_op_ready && (r_state == S_IDLE);

  // Loader FSM with registered handshake, write port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= c_base_addr;
      r_wdata    <= 32'h0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
    end else if (clear) begin
      // Clear restarts the pointer but keeps the last written word on wdata
      r_state    <= S_IDLE;
      r_op_ready <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= c_base_addr;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_state    <= S_WRITE;
              r_op_ready <= 1'b0;
              r_we       <= 1'b1;
              r_wdata    <= w_word;
            end else begin
              r_err      <= 1'b1;
            end
          end else begin
            r_op_ready <= 1'b1;
          end
        end
        S_WRITE: begin
          r_we    <= 1'b0;
          r_count <= w_count_nxt;
          r_addr  <= c_base_addr + w_count_nxt[ADDR_W-1:0];
          if (w_count_nxt == c_depth) begin
            r_state    <= S_FULL;
            r_full     <= 1'b1;
            r_op_ready <= 1'b0;
          end else begin
            r_state    <= S_IDLE;
            r_op_ready <= 1'b1;
          end
        end
        S_FULL: begin
          r_op_ready <= 1'b0;
          r_full     <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_op_ready <= 1'b0;
          r_we       <= 1'b0;
        end
      endcase
    end
  end

  // A clear arriving during the write cycle kills the strobe in that cycle
  assign bus.imem_we    = r_we & ~clear;
  assign bus.op_ready   = r_op_ready;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.count      = r_count;
  assign bus.full       = r_full;
  assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder_loader
//  Description : Directed self-checking bench for instr_encoder_loader
//                (ADDR_W=8, DEPTH=4, BASE_ADDR=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;

  logic clk;
  logic rst_n;
  logic clear;
  int   n_vec;
  int   n_err;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) lif ();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(4), .BASE_ADDR(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (lif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one descriptor, wait (bounded) for acceptance, capture the strobe
  // cycle, then return one cycle later (just after the end of the write cycle).
  task automatic apply_op(input logic [4:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                          output logic we, output logic [7:0] addr, output logic [31:0] wdata);
    bit seen;
    @(negedge clk);
    lif.op_kind = kind; lif.rs = rs; lif.rt = rt; lif.rd = rd; lif.imm = imm; lif.target = tgt;
    lif.op_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (lif.op_ready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) $display("FAIL handshake: op_ready never rose (got 0, need 1)");
    @(posedge clk); #1;
    lif.op_valid = 1'b0;
    we = lif.imem_we; addr = lif.imem_addr; wdata = lif.imem_wdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0;
    lif.op_valid = 1'b0; lif.op_kind = '0; lif.rs = '0; lif.rt = '0; lif.rd = '0;
    lif.imm = '0; lif.target = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (lif.op_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b need 0", lif.op_ready); end
    n_vec++; if (lif.imem_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b need 0", lif.imem_we); end
    n_vec++; if (lif.imem_addr !== 8'd16) begin n_err++; $display("FAIL reset_addr: got %0d need 16", lif.imem_addr); end
    n_vec++; if (lif.imem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h need 0", lif.imem_wdata); end
    n_vec++; if (lif.count !== 9'd0) begin n_err++; $display("FAIL reset_count: got %0d need 0", lif.count); end
    n_vec++; if (lif.full !== 1'b0 || lif.err !== 1'b0) begin n_err++; $display("FAIL reset_flags: got full=%b err=%b need 0 0", lif.full, lif.err); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (lif.op_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b need 1", lif.op_ready); end
  endtask

  task automatic test_add();
    logic we; logic [7:0] a; logic [31:0] d;
    apply_op(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, we, a, d);
    n_vec++; if (we !== 1'b1 || a !== 8'd16 || d !== 32'h00221820) begin n_err++; $display("FAIL add: got we=%b addr=%0d data=%h need 1 16 00221820", we, a, d); end
    n_vec++; if (lif.count !== 9'd1 || lif.imem_we !== 1'b0 || lif.op_ready !== 1'b1) begin n_err++; $display("FAIL add_after: got count=%0d we=%b rdy=%b need 1 0 1", lif.count, lif.imem_we, lif.op_ready); end
    n_vec++; if (lif.imem_addr !== 8'd17 || lif.imem_wdata !== 32'h00221820) begin n_err++; $display("FAIL add_hold: got addr=%0d data=%h need 17 00221820", lif.imem_addr, lif.imem_wdata); end
  endtask

  task automatic test_addi_jr();
    logic we; logic [7:0] a; logic [31:0] d;
    apply_op(5'd10, 5'd0, 5'd4, 5'd9, 16'hFFFF, 26'h0, we, a, d);
    n_vec++; if (we !== 1'b1 || a !== 8'd17 || d !== 32'h2004FFFF) begin n_err++; $display("FAIL addi: got we=%b addr=%0d data=%h need 1 17 2004ffff", we, a, d); end
    apply_op(5'd9, 5'd31, 5'd7, 5'd7, 16'h1234, 26'h0, we, a, d);
    n_vec++; if (we !== 1'b1 || a !== 8'd18 || d !== 32'h03E00008) begin n_err++; $display("FAIL jr: got we=%b addr=%0d data=%h need 1 18 03e00008", we, a, d); end
    n_vec++; if (lif.count !== 9'd3) begin n_err++; $display("FAIL jr_count: got %0d need 3", lif.count); end
  endtask

  task automatic test_jal_sw();
    logic we; logic [7:0] a; logic [31:0] d;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    apply_op(5'd23, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, we, a, d);
    n_vec++; if (we !== 1'b1 || a !== 8'd16 || d !== 32'h0C000010) begin n_err++; $display("FAIL jal: got we=%b addr=%0d data=%h need 1 16 0c000010", we, a, d); end
    apply_op(5'd25, 5'd29, 5'd31, 5'd0, 16'h0008, 26'h0, we, a, d);
    n_vec++; if (we !== 1'b1 || a !== 8'd17 || d !== 32'hAFBF0008) begin n_err++; $display("FAIL sw: got we=%b addr=%0d data=%h need 1 17 afbf0008", we, a, d); end
  endtask

  task automatic test_illegal();
    logic we; logic [7:0] a; logic [31:0] d;
    apply_op(5'd31, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, we, a, d);
    n_vec++; if (we !== 1'b0 || lif.err !== 1'b1) begin n_err++; $display("FAIL illegal: got we=%b err=%b need 0 1", we, lif.err); end
    n_vec++; if (lif.count !== 9'd2 || lif.op_ready !== 1'b1) begin n_err++; $display("FAIL illegal_state: got count=%0d rdy=%b need 2 1", lif.count, lif.op_ready); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (lif.err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b need 1", lif.err); end
    // clear together with a legal descriptor: clear wins
    @(negedge clk);
    lif.op_kind = 5'd0; lif.op_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; lif.op_valid = 1'b0;
    n_vec++; if (lif.err !== 1'b0 || lif.count !== 9'd0 || lif.imem_addr !== 8'd16) begin n_err++; $display("FAIL clear_wins: got err=%b count=%0d addr=%0d need 0 0 16", lif.err, lif.count, lif.imem_addr); end
    @(posedge clk); #1;
    n_vec++; if (lif.imem_we !== 1'b0 || lif.op_ready !== 1'b1) begin n_err++; $display("FAIL clear_no_accept: got we=%b rdy=%b need 0 1", lif.imem_we, lif.op_ready); end
  endtask

  task automatic test_full();
    logic we; logic [7:0] a; logic [31:0] d;
    apply_op(5'd8, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, we, a, d);
    n_vec++; if (we !== 1'b1 || a !== 8'd16 || d !== 32'h00A6382A) begin n_err++; $display("FAIL slt: got we=%b addr=%0d data=%h need 1 16 00a6382a", we, a, d); end
    apply_op(5'd21, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0, we, a, d);
    n_vec++; if (we !== 1'b1 || a !== 8'd17 || d !== 32'h78220010) begin n_err++; $display("FAIL bleq: got we=%b addr=%0d data=%h need 1 17 78220010", we, a, d); end
    apply_op(5'd6, 5'd0, 5'd2, 5'd3, 16'h0, 26'h0, we, a, d);
    n_vec++; if (we !== 1'b1 || a !== 8'd18 || d !== 32'h00021800) begin n_err++; $display("FAIL sll: got we=%b addr=%0d data=%h need 1 18 00021800", we, a, d); end
    n_vec++; if (lif.full !== 1'b0) begin n_err++; $display("FAIL early_full: got %b need 0", lif.full); end
    apply_op(5'd22, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, we, a, d);
    n_vec++; if (we !== 1'b1 || a !== 8'd19 || d !== 32'h0BFFFFFF) begin n_err++; $display("FAIL j: got we=%b addr=%0d data=%h need 1 19 0bffffff", we, a, d); end
    n_vec++; if (lif.full !== 1'b1 || lif.op_ready !== 1'b0 || lif.count !== 9'd4) begin n_err++; $display("FAIL full: got full=%b rdy=%b count=%0d need 1 0 4", lif.full, lif.op_ready, lif.count); end
    @(negedge clk);
    lif.op_kind = 5'd0; lif.op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_vec++; if (lif.imem_we !== 1'b0 || lif.op_ready !== 1'b0 || lif.count !== 9'd4) begin n_err++; $display("FAIL full_hold: got we=%b rdy=%b count=%0d need 0 0 4", lif.imem_we, lif.op_ready, lif.count); end
    end
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; lif.op_valid = 1'b0;
    n_vec++; if (lif.count !== 9'd0 || lif.imem_addr !== 8'd16 || lif.op_ready !== 1'b1 || lif.full !== 1'b0) begin n_err++; $display("FAIL full_clear: got count=%0d addr=%0d rdy=%b full=%b need 0 16 1 0", lif.count, lif.imem_addr, lif.op_ready, lif.full); end
  endtask

  task automatic test_clear_in_write();
    logic we; logic [7:0] a; logic [31:0] d;
    apply_op(5'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, we, a, d);  // count -> 1
    @(negedge clk);
    lif.op_kind = 5'd3; lif.op_valid = 1'b1;
    @(posedge clk); #1;
    lif.op_valid = 1'b0;
    clear = 1'b1; #1;
    n_vec++; if (lif.imem_we !== 1'b0) begin n_err++; $display("FAIL clear_write_strobe: got %b need 0", lif.imem_we); end
    @(posedge clk); #1;
    clear = 1'b0;
    n_vec++; if (lif.count !== 9'd0 || lif.imem_we !== 1'b0) begin n_err++; $display("FAIL clear_write_count: got count=%0d we=%b need 0 0", lif.count, lif.imem_we); end
  endtask

  task automatic test_reset_in_write();
    logic we; logic [7:0] a; logic [31:0] d;
    apply_op(5'd4, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, we, a, d);  // count -> 1
    @(negedge clk);
    lif.op_kind = 5'd5; lif.op_valid = 1'b1;
    @(posedge clk); #1;
    lif.op_valid = 1'b0;
    n_vec++; if (lif.imem_we !== 1'b1) begin n_err++; $display("FAIL pre_reset_strobe: got %b need 1", lif.imem_we); end
    rst_n = 1'b0; #1;
    n_vec++; if (lif.imem_we !== 1'b0 || lif.count !== 9'd0 || lif.imem_addr !== 8'd16) begin n_err++; $display("FAIL async_reset: got we=%b count=%0d addr=%0d need 0 0 16", lif.imem_we, lif.count, lif.imem_addr); end
    @(negedge clk); rst_n = 1'b1;
    apply_op(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, we, a, d);
    n_vec++; if (we !== 1'b1 || a !== 8'd16 || d !== 32'h00221820) begin n_err++; $display("FAIL after_reset_write: got we=%b addr=%0d data=%h need 1 16 00221820", we, a, d); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_add();
    test_addi_jr();
    test_jal_sw();
    test_illegal();
    test_full();
    test_clear_in_write();
    test_reset_in_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time guard so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at limit");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
